// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan sequencer.
package seg_pkg;

    localparam int DIGITS_DEF = 4;
    localparam int WORD_W_DEF = 16;

    localparam logic [15:0] BLANK_WORD = 16'h0000;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } seg_state_e;

    // Cycles spent on one digit: load + shift + latch + dwell.
    function automatic int digit_period(input int word_w, input int hold_cycles);
        return word_w + hold_cycles + 2;
    endfunction

endpackage

// File: rtl/seg_scan_sequencer_if.sv
// Update handshake and display-link signals of the scan sequencer.
interface seg_scan_sequencer_if #(
    parameter int DIGITS = 4,
    parameter int WORD_W = 16
) ();
    localparam int DIG_W = $clog2(DIGITS);

    logic                     upd_valid;
    logic                     upd_ready;
    logic [DIGITS*WORD_W-1:0] upd_words;
    logic                     seg_data;
    logic                     seg_latch;
    logic [DIG_W-1:0]         cur_digit;
    logic                     frame_done;

    modport master (
        output upd_valid, upd_words,
        input  upd_ready, seg_data, seg_latch, cur_digit, frame_done
    );

    modport slave (
        input  upd_valid, upd_words,
        output upd_ready, seg_data, seg_latch, cur_digit, frame_done
    );
endinterface

// File: rtl/seg_shift_engine.sv
// Load/shift register for one digit word, MSB first, with a bit counter.
module seg_shift_engine #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_word,
    input  logic              shift_en,
    output logic              msb,
    output logic              shift_done
);
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load_en) begin
            shreg_d   = load_word;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign msb        = shreg_q[WORD_W-1];
    // High during the cycle that presents the final bit.
    assign shift_done = shift_en && (bit_cnt_q == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/seg_scan_sequencer.sv
// Four-phase digit scanner with frame-boundary content swap.
// Optional input `blank` is present when SEG_BLANK_EN is defined.
module seg_scan_sequencer
    import seg_pkg::*;
#(
    parameter int DIGITS      = DIGITS_DEF,
    parameter int WORD_W      = WORD_W_DEF,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SEG_BLANK_EN
    input  logic blank,
`endif
    seg_scan_sequencer_if.slave bus
);
    localparam int DIG_W  = $clog2(DIGITS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    seg_state_e        state_q, state_d;
    logic [DIG_W-1:0]  cur_digit_q, cur_digit_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_q, pend_d;
    logic              upd_ready_q, upd_ready_d;
    logic [WORD_W-1:0] shadow_q  [DIGITS];
    logic [WORD_W-1:0] shadow_d  [DIGITS];
    logic [WORD_W-1:0] pending_q [DIGITS];
    logic [WORD_W-1:0] pending_d [DIGITS];
    logic [WORD_W-1:0] in_words  [DIGITS];

    logic              load_en, shift_en, shift_msb, shift_done;
    logic              frame_end, accept;
    logic [WORD_W-1:0] load_word;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_unpack
            assign in_words[gi] = bus.upd_words[gi*WORD_W +: WORD_W];
        end
    endgenerate

`ifdef SEG_BLANK_EN
    assign load_word = blank ? WORD_W'(BLANK_WORD) : shadow_q[cur_digit_q];
`else
    assign load_word = shadow_q[cur_digit_q];
`endif

    seg_shift_engine #(.WORD_W(WORD_W)) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_word  (load_word),
        .shift_en   (shift_en),
        .msb        (shift_msb),
        .shift_done (shift_done)
    );

    always_comb begin
        state_d     = state_q;
        cur_digit_d = cur_digit_q;
        hold_cnt_d  = hold_cnt_q;
        load_en     = 1'b0;
        shift_en    = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            LOAD: begin
                load_en = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (shift_done) state_d = LATCH;
            end
            LATCH: begin
                hold_cnt_d = '0;
                state_d    = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = LOAD;
                    frame_end   = (cur_digit_q == DIG_LAST);
                    cur_digit_d = frame_end ? '0 : cur_digit_q + DIG_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // An accept on the boundary cycle only fills pending; the swap
    // uses the pend flag as it stood before this cycle.
    always_comb begin
        accept    = bus.upd_valid && upd_ready_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_end && pend_q) begin
            shadow_d = pending_q;
            pend_d   = 1'b0;
        end
        if (accept) begin
            pending_d = in_words;
            pend_d    = 1'b1;
        end
        upd_ready_d = !pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cur_digit_q <= '0;
            hold_cnt_q  <= '0;
            pend_q      <= 1'b0;
            upd_ready_q <= 1'b1;
            for (int i = 0; i < DIGITS; i++) shadow_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cur_digit_q <= cur_digit_d;
            hold_cnt_q  <= hold_cnt_d;
            pend_q      <= pend_d;
            upd_ready_q <= upd_ready_d;
            shadow_q    <= shadow_d;
        end
    end

    // Pending contents are only meaningful while pend is set.
    always_ff @(posedge clk) begin
        pending_q <= pending_d;
    end

    assign bus.seg_data   = (state_q == SHIFT) && shift_msb;
    assign bus.seg_latch  = (state_q == LATCH);
    assign bus.frame_done = frame_end;
    assign bus.cur_digit  = cur_digit_q;
    assign bus.upd_ready  = upd_ready_q;

endmodule
